// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
// The move table uses the same one-hot bit ordering as the tour solver.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N_DEF = 8'h00;
    localparam logic [7:0] HDG_W_DEF = 8'h3F;
    localparam logic [7:0] HDG_S_DEF = 8'h7F;
    localparam logic [7:0] HDG_E_DEF = 8'hBF;

    localparam int NUM_MOVES_DEF = 24;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } delta_t;

    // Knight displacement for the move encoded by one-hot bit position b.
    function automatic delta_t move_delta(input logic [2:0] b);
        delta_t d;
        case (b)
            3'd0:    begin d.dx = -3'sd1; d.dy =  3'sd2; end
            3'd1:    begin d.dx =  3'sd1; d.dy =  3'sd2; end
            3'd2:    begin d.dx = -3'sd2; d.dy =  3'sd1; end
            3'd3:    begin d.dx = -3'sd2; d.dy = -3'sd1; end
            3'd4:    begin d.dx = -3'sd1; d.dy = -3'sd2; end
            3'd5:    begin d.dx =  3'sd1; d.dy = -3'sd2; end
            3'd6:    begin d.dx =  3'sd2; d.dy =  3'sd1; end
            default: begin d.dx =  3'sd2; d.dy = -3'sd1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command-processor handshake bus: cmd/cmd_rdy forward, clr_cmd_rdy and
// send_resp returned by the command processor.
interface tour_cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;

    modport master (output cmd, output cmd_rdy, input clr_cmd_rdy, input send_resp);
    modport slave  (input cmd, input cmd_rdy, output clr_cmd_rdy, output send_resp);
endinterface

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into a vertical-leg and a
// horizontal-leg drive command. Build option TOUR_CMD_FANFARE_EN makes the
// horizontal leg use the fanfare opcode.
module tour_move_decode
    import tour_pkg::*;
#(
    parameter logic [7:0] HDG_N = HDG_N_DEF,
    parameter logic [7:0] HDG_W = HDG_W_DEF,
    parameter logic [7:0] HDG_S = HDG_S_DEF,
    parameter logic [7:0] HDG_E = HDG_E_DEF
) (
    input  logic [7:0]  move_i,
    output logic [15:0] vert_cmd_o,
    output logic [15:0] horz_cmd_o,
    output logic        valid_o
);

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] HORZ_OP = OP_FANFARE;
`else
    localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

    delta_t     d;
    logic [2:0] adx;
    logic [2:0] ady;

    // Look up the displacement of the set bit and form both leg commands.
    always_comb begin
        d = '0;
        for (int i = 0; i < 8; i++) begin
            if (move_i[i]) d = move_delta(3'(i));
        end
        adx        = (d.dx < 3'sd0) ? -d.dx : d.dx;
        ady        = (d.dy < 3'sd0) ? -d.dy : d.dy;
        vert_cmd_o = {OP_MOVE, (d.dy > 3'sd0) ? HDG_N : HDG_S, 1'b0, ady};
        horz_cmd_o = {HORZ_OP, (d.dx > 3'sd0) ? HDG_E : HDG_W, 1'b0, adx};
        valid_o    = $onehot(move_i);
    end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as drive commands (vertical leg, then
// horizontal leg per move) and passes UART commands through when idle.
// Optional build macro: TOUR_CMD_FANFARE_EN (fanfare opcode on horizontal legs).
module tour_cmd
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES = NUM_MOVES_DEF,
    parameter logic [7:0] HDG_N     = HDG_N_DEF,
    parameter logic [7:0] HDG_W     = HDG_W_DEF,
    parameter logic [7:0] HDG_S     = HDG_S_DEF,
    parameter logic [7:0] HDG_E     = HDG_E_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    tour_cmd_if.master  cmd_bus,
    output logic        tour_active,
    output logic        tour_done,
    output logic        move_err
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t      state_q;
    logic [4:0]  mv_indx_q;
    logic        active_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] tcmd_q;
    logic        trdy_q;

    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        mv_valid;

    tour_move_decode #(
        .HDG_N (HDG_N),
        .HDG_W (HDG_W),
        .HDG_S (HDG_S),
        .HDG_E (HDG_E)
    ) u_decode (
        .move_i     (move),
        .vert_cmd_o (vert_cmd),
        .horz_cmd_o (horz_cmd),
        .valid_o    (mv_valid)
    );

    // Tour sequencer: fetch move, issue vertical leg, wait, issue horizontal leg, wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tcmd_q    <= '0;
            trdy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx_q <= '0;
                        active_q  <= 1'b1;
                        state_q   <= VERT;
                    end
                end
                VERT: begin
                    if (!mv_valid) begin
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        tcmd_q  <= vert_cmd;
                        trdy_q  <= 1'b1;
                        state_q <= WAIT_V;
                    end
                end
                WAIT_V: begin
                    // A response without a prior clear still retires the command.
                    if (cmd_bus.clr_cmd_rdy || cmd_bus.send_resp) trdy_q <= 1'b0;
                    if (cmd_bus.send_resp) state_q <= HORZ;
                end
                HORZ: begin
                    tcmd_q  <= horz_cmd;
                    trdy_q  <= 1'b1;
                    state_q <= WAIT_H;
                end
                WAIT_H: begin
                    if (cmd_bus.clr_cmd_rdy || cmd_bus.send_resp) trdy_q <= 1'b0;
                    if (cmd_bus.send_resp) begin
                        if (mv_indx_q == LAST_INDX) begin
                            done_q    <= 1'b1;
                            active_q  <= 1'b0;
                            mv_indx_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            mv_indx_q <= mv_indx_q + 5'd1;
                            state_q   <= VERT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // UART owns the command processor whenever no tour is running.
    assign cmd_bus.cmd      = (state_q == IDLE) ? cmd_UART : tcmd_q;
    assign cmd_bus.cmd_rdy  = (state_q == IDLE) ? cmd_rdy_UART : trdy_q;
    assign clr_cmd_rdy_UART = (state_q == IDLE) && cmd_bus.clr_cmd_rdy;

    assign mv_indx     = mv_indx_q;
    assign tour_active = active_q;
    assign tour_done   = done_q;
    assign move_err    = err_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: randomized tours against a reference
// model that derives leg commands directly from knight displacements.
module tb_tour_cmd;

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] HOP = 4'h3;
`else
    localparam logic [3:0] HOP = 4'h2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        tour_active;
    logic        tour_done;
    logic        move_err;
    logic [7:0]  mem [0:31];

    int tests = 0;
    int fails = 0;
    int rises = 0;
    logic prev_rdy = 1'b0;

    tour_cmd_if bus ();

    tour_cmd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd_bus          (bus),
        .tour_active      (tour_active),
        .tour_done        (tour_done),
        .move_err         (move_err)
    );

    always #5 clk = ~clk;

    // Solver read port emulation.
    assign move = mem[mv_indx];

    // Count rising edges of cmd_rdy.
    always @(negedge clk) begin
        if (bus.cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rises <= rises + 1;
        prev_rdy <= bus.cmd_rdy;
    end

    // Reference: knight displacement -> leg command.
    function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit horz);
        int dxs [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dys [8] = '{2, 2, 1, -1, -2, -2, 1, -1};
        int dx = 0;
        int dy = 0;
        int cnt;
        logic [7:0] hdg;
        logic [3:0] op;
        for (int k = 0; k < 8; k++) if (mv[k]) begin dx = dxs[k]; dy = dys[k]; end
        if (horz) begin
            op  = HOP;
            hdg = (dx > 0) ? 8'hBF : 8'h3F;
            cnt = (dx < 0) ? -dx : dx;
        end else begin
            op  = 4'h2;
            hdg = (dy > 0) ? 8'h00 : 8'h7F;
            cnt = (dy < 0) ? -dy : dy;
        end
        return {op, hdg, 4'(cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_pulse();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = 8'h01 << $urandom_range(7, 0);
    endtask

    // Wait for a leg command, check it, hold one cycle, then acknowledge.
    task automatic serve_leg(input logic [15:0] exp, input int idx, input string nm, input bit coincide);
        int n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL %s idx%0d rdy_timeout: got %b want 1", nm, idx, bus.cmd_rdy);
        end
        tests++;
        if (bus.cmd !== exp) begin
            fails++; $display("FAIL %s idx%0d cmd: got %h want %h", nm, idx, bus.cmd, exp);
        end
        tests++;
        if (mv_indx !== 5'(idx)) begin
            fails++; $display("FAIL %s mv_indx: got %0d want %0d", nm, mv_indx, idx);
        end
        tick();
        tests++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp) begin
            fails++; $display("FAIL %s idx%0d hold: got rdy=%b cmd=%h want rdy=1 cmd=%h", nm, idx, bus.cmd_rdy, bus.cmd, exp);
        end
        bus.clr_cmd_rdy = 1'b1;
        if (coincide) bus.send_resp = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        tests++;
        if (bus.cmd_rdy !== 1'b0) begin
            fails++; $display("FAIL %s idx%0d rdy_after_clr: got %b want 0", nm, idx, bus.cmd_rdy);
        end
        if (!coincide) begin
            tick();
            bus.send_resp = 1'b1;
            tick();
            bus.send_resp = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_tour = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        fill_random();
        #1;
        tests++;
        if (mv_indx !== 5'd0 || tour_active !== 1'b0 || tour_done !== 1'b0 || move_err !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got indx=%0d act=%b done=%b err=%b want 0 0 0 0",
                              mv_indx, tour_active, tour_done, move_err);
        end
        tests++;
        if (bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_passthru: got cmd=%h rdy=%b want 1234 1", bus.cmd, bus.cmd_rdy);
        end
        cmd_rdy_UART = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_moves();
        fill_random();
        mem[0] = 8'h02;
        mem[1] = 8'h08;
        start_pulse();
        tests++;
        if (tour_active !== 1'b1 || bus.cmd_rdy !== 1'b0) begin
            fails++; $display("FAIL latency_n1: got act=%b rdy=%b want 1 0", tour_active, bus.cmd_rdy);
        end
        tick();
        tests++;
        if (bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL latency_n2: got rdy=%b want 1", bus.cmd_rdy);
        end
        serve_leg(16'h2002, 0, "fixed_v02", 1'b0);
        serve_leg({HOP, 12'hBF1}, 0, "fixed_h02", 1'b0);
        serve_leg(16'h27F1, 1, "fixed_v08", 1'b0);
        serve_leg({HOP, 12'h3F2}, 1, "fixed_h08", 1'b0);
        do_reset();
    endtask

    task automatic test_full_replay();
        int r0;
        fill_random();
        r0 = rises;
        start_pulse();
        for (int i = 0; i < 24; i++) begin
            serve_leg(model_cmd(mem[i], 1'b0), i, "replay_v", 1'b0);
            if (i == 12) start_pulse();
            serve_leg(model_cmd(mem[i], 1'b1), i, "replay_h", 1'b0);
            if (i < 23) begin
                tests++;
                if (tour_done !== 1'b0) begin
                    fails++; $display("FAIL replay_early_done idx%0d: got %b want 0", i, tour_done);
                end
            end
        end
        tests++;
        if (tour_done !== 1'b1 || tour_active !== 1'b0 || mv_indx !== 5'd0) begin
            fails++; $display("FAIL replay_end: got done=%b act=%b indx=%0d want 1 0 0", tour_done, tour_active, mv_indx);
        end
        tests++;
        if (rises - r0 !== 48) begin
            fails++; $display("FAIL replay_rdy_count: got %0d want 48", rises - r0);
        end
        tick();
        tests++;
        if (tour_done !== 1'b0) begin
            fails++; $display("FAIL replay_done_pulse: got %b want 0", tour_done);
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        start_pulse();
        for (int i = 0; i < 24; i++) begin
            serve_leg(model_cmd(mem[i], 1'b0), i, "b2b_v", 1'($urandom_range(1, 0)));
            serve_leg(model_cmd(mem[i], 1'b1), i, "b2b_h", 1'($urandom_range(1, 0)));
        end
        tests++;
        if (tour_done !== 1'b1 || tour_active !== 1'b0) begin
            fails++; $display("FAIL b2b_end: got done=%b act=%b want 1 0", tour_done, tour_active);
        end
        tick();
    endtask

    task automatic test_move_err(input logic [7:0] bad);
        int r0;
        fill_random();
        mem[5] = bad;
        start_pulse();
        for (int i = 0; i < 5; i++) begin
            serve_leg(model_cmd(mem[i], 1'b0), i, "err_v", 1'b0);
            serve_leg(model_cmd(mem[i], 1'b1), i, "err_h", 1'b0);
        end
        r0 = rises;
        tick();
        tests++;
        if (move_err !== 1'b1 || tour_active !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
            fails++; $display("FAIL move_err_%h: got err=%b act=%b rdy=%b want 1 0 0", bad, move_err, tour_active, bus.cmd_rdy);
        end
        cmd_UART = 16'h2777; cmd_rdy_UART = 1'b1;
        tick();
        tests++;
        if (move_err !== 1'b0 || bus.cmd !== 16'h2777 || rises - r0 !== 1) begin
            fails++; $display("FAIL move_err_idle_%h: got err=%b cmd=%h rises=%0d want 0 2777 1",
                              bad, move_err, bus.cmd, rises - r0);
        end
        cmd_rdy_UART = 1'b0;
        tick();
    endtask

    task automatic test_uart_pass();
        cmd_UART = 16'h2005; cmd_rdy_UART = 1'b1;
        #1;
        tests++;
        if (bus.cmd !== 16'h2005 || bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL uart_fwd: got cmd=%h rdy=%b want 2005 1", bus.cmd, bus.cmd_rdy);
        end
        bus.clr_cmd_rdy = 1'b1;
        #1;
        tests++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            fails++; $display("FAIL uart_clr: got %b want 1", clr_cmd_rdy_UART);
        end
        tick();
        bus.clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        fill_random();
        mem[0] = 8'h40;
        start_pulse();
        tick();
        cmd_rdy_UART = 1'b1; bus.clr_cmd_rdy = 1'b1;
        #1;
        tests++;
        if (bus.cmd !== 16'h2001 || clr_cmd_rdy_UART !== 1'b0) begin
            fails++; $display("FAIL uart_blocked: got cmd=%h clr_uart=%b want 2001 0", bus.cmd, clr_cmd_rdy_UART);
        end
        tick();
        bus.clr_cmd_rdy = 1'b0;
        tests++;
        if (bus.cmd_rdy !== 1'b0) begin
            fails++; $display("FAIL uart_rdy_blocked: got %b want 0", bus.cmd_rdy);
        end
        do_reset();
        tests++;
        if (bus.cmd !== 16'h2005 || bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL uart_after_tour: got cmd=%h rdy=%b want 2005 1", bus.cmd, bus.cmd_rdy);
        end
        cmd_rdy_UART = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        fill_random();
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            serve_leg(model_cmd(mem[i], 1'b0), i, "mid_v", 1'b0);
            serve_leg(model_cmd(mem[i], 1'b1), i, "mid_h", 1'b0);
        end
        serve_leg(model_cmd(mem[10], 1'b0), 10, "mid_v", 1'b0);
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin tick(); n++; end
        cmd_UART = 16'hABCD; cmd_rdy_UART = 1'b1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (tour_active !== 1'b0 || mv_indx !== 5'd0 || bus.cmd !== 16'hABCD || bus.cmd_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_mid: got act=%b indx=%0d cmd=%h rdy=%b want 0 0 abcd 1",
                              tour_active, mv_indx, bus.cmd, bus.cmd_rdy);
        end
        cmd_rdy_UART = 1'b0;
        #1;
        tests++;
        if (bus.cmd_rdy !== 1'b0) begin
            fails++; $display("FAIL reset_mid_mirror: got %b want 0", bus.cmd_rdy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_pulse();
        serve_leg(model_cmd(mem[0], 1'b0), 0, "restart_v", 1'b0);
        serve_leg(model_cmd(mem[0], 1'b1), 0, "restart_h", 1'b0);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fixed_moves();
        test_full_replay();
        test_back_to_back();
        test_move_err(8'h00);
        test_move_err(8'h03);
        test_uart_pass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
